// File: rtl/enemy_spawn_sched_pkg.sv
// ---------------------------------------------------------------------------
// enemy_spawn_sched_pkg
//   Shared constants for the enemy spawn scheduler: default geometry, spawn
//   periods, global enemy cap, difficulty ramp length, class ids, FSM state
//   codes and two small helpers (mod-3 class arithmetic, ramped reload).
//   No ports.
// ---------------------------------------------------------------------------
package enemy_spawn_sched_pkg;

    localparam int ENEMY_SPAWN_NUM_SLOTS   = 8;
    localparam int ENEMY_SPAWN_SLOT_BW     = 3;
    localparam int ENEMY_SPAWN_X_BW        = 9;
    localparam int ENEMY_SPAWN_X_RANGE     = 400;
    localparam int ENEMY_SPAWN_RAND_W      = 10;
    localparam int ENEMY_SPAWN_PERIOD0     = 30;
    localparam int ENEMY_SPAWN_PERIOD1     = 90;
    localparam int ENEMY_SPAWN_PERIOD2     = 240;
    localparam int ENEMY_SPAWN_MAX_ACTIVE  = 12;
    localparam int ENEMY_SPAWN_RAMP_FRAMES = 1800;

    // Class ids (enemy1/2/3)
    localparam logic [1:0] CLS_ENEMY1 = 2'd0;
    localparam logic [1:0] CLS_ENEMY2 = 2'd1;
    localparam logic [1:0] CLS_ENEMY3 = 2'd2;

    // FSM state codes
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_FIRE = 2'd2;

    // (a + b) mod 3 for class ids a, b in 0..2
    function automatic logic [1:0] cls_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end else begin
            s = s;
        end
        return 2'(s);
    endfunction

    // Period shortened by the difficulty level, never below one frame
    function automatic logic [7:0] reload_of(input logic [7:0] period, input logic [1:0] lvl);
        logic [7:0] r;
        r = period >> lvl;
        if (r == 8'd0) begin
            r = 8'd1;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/enemy_spawn_sched_slot_finder.sv
// ---------------------------------------------------------------------------
// enemy_spawn_sched_slot_finder
//   Combinational lowest-free-slot search over one class's free mask.
//   Ports:
//     free_i  in  NUM_SLOTS  1 = slot free
//     found_o out 1          at least one slot free
//     idx_o   out SLOT_BW    lowest free slot index (0 when none free)
// ---------------------------------------------------------------------------
module enemy_spawn_sched_slot_finder
    import enemy_spawn_sched_pkg::*;
#(
    parameter int NUM_SLOTS = ENEMY_SPAWN_NUM_SLOTS,
    parameter int SLOT_BW   = ENEMY_SPAWN_SLOT_BW
) (
    input  logic [NUM_SLOTS-1:0] free_i,
    output logic                 found_o,
    output logic [SLOT_BW-1:0]   idx_o
);

    // Scan high to low so the last hit written is the lowest free index
    always_comb begin
        found_o = |free_i;
        idx_o   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_i[i]) begin
                idx_o = SLOT_BW'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

endmodule

// File: rtl/enemy_spawn_sched.sv
// ---------------------------------------------------------------------------
// enemy_spawn_sched
//   Central spawn scheduler for the three enemy classes (clk_vga domain).
//   Once per frame (v_sync rising edge) it ages the per-class period
//   counters and grants at most one spawn, round-robin among expired classes
//   that have a free slot while the global enemy count is below the cap.
//   The spawn pulse appears on trigger_o three clocks after the v_sync edge.
//   Optional difficulty ramp: define ENEMY_SPAWN_RAMP_EN to raise level_o
//   every RAMP_FRAMES enabled frames and shorten the reload periods.
//   Ports:
//     clk_vga        in  1            pixel clock
//     rst            in  1            asynchronous, active-high reset
//     en_i           in  1            game running
//     v_sync_i       in  1            frame sync (clk_vga synchronous)
//     rand_i         in  RAND_W       LFSR value, source of x position
//     disappear_i    in  3*NUM_SLOTS  1 = slot free; class c at [c*NUM_SLOTS +: NUM_SLOTS]
//     trigger_o      out 3            one-hot one-cycle spawn pulse
//     trigger_idx_o  out SLOT_BW      spawned slot, held between pulses
//     trigger_x_o    out X_BW         spawn x origin, held between pulses
//     active_cnt_o   out 5            visible enemy count (combinational)
//     level_o        out 2            difficulty level
// ---------------------------------------------------------------------------
module enemy_spawn_sched
    import enemy_spawn_sched_pkg::*;
#(
    parameter int NUM_SLOTS   = ENEMY_SPAWN_NUM_SLOTS,
    parameter int SLOT_BW     = ENEMY_SPAWN_SLOT_BW,
    parameter int X_BW        = ENEMY_SPAWN_X_BW,
    parameter int X_RANGE     = ENEMY_SPAWN_X_RANGE,
    parameter int RAND_W      = ENEMY_SPAWN_RAND_W,
    parameter int PERIOD0     = ENEMY_SPAWN_PERIOD0,
    parameter int PERIOD1     = ENEMY_SPAWN_PERIOD1,
    parameter int PERIOD2     = ENEMY_SPAWN_PERIOD2,
    parameter int MAX_ACTIVE  = ENEMY_SPAWN_MAX_ACTIVE
`ifdef ENEMY_SPAWN_RAMP_EN
   ,parameter int RAMP_FRAMES = ENEMY_SPAWN_RAMP_FRAMES
`endif
) (
    input  logic                   clk_vga,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic                   v_sync_i,
    input  logic [RAND_W-1:0]      rand_i,
    input  logic [3*NUM_SLOTS-1:0] disappear_i,
    output logic [2:0]             trigger_o,
    output logic [SLOT_BW-1:0]     trigger_idx_o,
    output logic [X_BW-1:0]        trigger_x_o,
    output logic [4:0]             active_cnt_o,
    output logic [1:0]             level_o
);

    function automatic logic [7:0] period_of(input logic [1:0] cls);
        case (cls)
            CLS_ENEMY1: period_of = 8'(PERIOD0);
            CLS_ENEMY2: period_of = 8'(PERIOD1);
            CLS_ENEMY3: period_of = 8'(PERIOD2);
            default:    period_of = 8'(PERIOD0);
        endcase
    endfunction

    logic [1:0]         state_q, state_d;
    logic [2:0][7:0]    cnt_q, cnt_d;
    logic [1:0]         rr_q, rr_d;
    logic [1:0]         cls_q, cls_d;
    logic [SLOT_BW-1:0] slot_q, slot_d;
    logic [X_BW-1:0]    x_q, x_d;
    logic [2:0]         trig_q, trig_d;
    logic [SLOT_BW-1:0] idx_q, idx_d;
    logic [X_BW-1:0]    xo_q, xo_d;
    logic               v_sync_q;

    logic               frame_tick_s;
    logic [4:0]         act_s;
    logic [2:0]         req_s;
    logic               gnt_found_s;
    logic [1:0]         gnt_cls_s;
    logic [1:0]         cand_s;
    logic [NUM_SLOTS-1:0] gnt_mask_s;
    logic               slot_found_s;
    logic [SLOT_BW-1:0] slot_idx_s;
    logic [RAND_W-1:0]  x_wrap_s;
    logic [1:0]         level_s;

    assign frame_tick_s = v_sync_i & ~v_sync_q;

    // Count visible enemies (busy slots) across all classes
    always_comb begin
        act_s = 5'd0;
        for (int i = 0; i < 3 * NUM_SLOTS; i++) begin
            act_s = act_s + {4'd0, ~disappear_i[i]};
        end
    end

    assign active_cnt_o = act_s;

    // A class requests when its period expired, it has a free slot and the cap allows
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            req_s[c] = (cnt_q[c] == 8'd0) && (|disappear_i[c*NUM_SLOTS +: NUM_SLOTS])
                       && (act_s < 5'(MAX_ACTIVE));
        end
    end

    // Round-robin pick: first requester at or after rr_q
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_cls_s   = rr_q;
        cand_s      = rr_q;
        for (int k = 0; k < 3; k++) begin
            cand_s = cls_add(rr_q, 2'(k));
            if (!gnt_found_s && req_s[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_cls_s   = cand_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    assign gnt_mask_s = disappear_i[gnt_cls_s*NUM_SLOTS +: NUM_SLOTS];

    enemy_spawn_sched_slot_finder #(
        .NUM_SLOTS (NUM_SLOTS),
        .SLOT_BW   (SLOT_BW)
    ) u_slot_finder (
        .free_i  (gnt_mask_s),
        .found_o (slot_found_s),
        .idx_o   (slot_idx_s)
    );

    // rand_i < 2*X_RANGE, so a single subtract reduces it mod X_RANGE
    assign x_wrap_s = (rand_i >= RAND_W'(X_RANGE)) ? (rand_i - RAND_W'(X_RANGE)) : rand_i;

`ifdef ENEMY_SPAWN_RAMP_EN
    localparam int FC_W = $clog2(RAMP_FRAMES + 1);

    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [1:0]      level_q, level_d;

    // Difficulty ramp: one level per RAMP_FRAMES enabled frames, saturating at 3
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        level_d     = level_q;
        if (frame_tick_s && en_i) begin
            if (frame_cnt_q == FC_W'(RAMP_FRAMES - 1)) begin
                frame_cnt_d = '0;
                level_d     = (level_q == 2'd3) ? 2'd3 : (level_q + 2'd1);
            end else begin
                frame_cnt_d = frame_cnt_q + FC_W'(1);
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Ramp registers
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            level_q     <= 2'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            level_q     <= level_d;
        end
    end

    assign level_s = level_q;
`else
    assign level_s = 2'd0;
`endif

    assign level_o = level_s;

    // Scheduler FSM: age counters on a frame tick, arbitrate, then fire
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        cls_d   = cls_q;
        slot_d  = slot_q;
        x_d     = x_q;
        trig_d  = 3'b000;
        idx_d   = idx_q;
        xo_d    = xo_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick_s && en_i) begin
                    for (int c = 0; c < 3; c++) begin
                        if (cnt_q[c] != 8'd0) begin
                            cnt_d[c] = cnt_q[c] - 8'd1;
                        end else begin
                            cnt_d[c] = 8'd0;
                        end
                    end
                    state_d = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB: begin
                if (en_i && gnt_found_s && slot_found_s) begin
                    cls_d   = gnt_cls_s;
                    slot_d  = slot_idx_s;
                    x_d     = X_BW'(x_wrap_s);
                    state_d = S_FIRE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FIRE: begin
                if (en_i) begin
                    trig_d[cls_q] = 1'b1;
                    idx_d         = slot_q;
                    xo_d          = x_q;
                    cnt_d[cls_q]  = reload_of(period_of(cls_q), level_s);
                    rr_d          = cls_add(cls_q, 2'd1);
                end else begin
                    trig_d = 3'b000;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Scheduler registers
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state_q            <= S_IDLE;
            cnt_q[CLS_ENEMY1]  <= period_of(CLS_ENEMY1);
            cnt_q[CLS_ENEMY2]  <= period_of(CLS_ENEMY2);
            cnt_q[CLS_ENEMY3]  <= period_of(CLS_ENEMY3);
            rr_q               <= CLS_ENEMY1;
            cls_q              <= CLS_ENEMY1;
            slot_q             <= '0;
            x_q                <= '0;
            trig_q             <= 3'b000;
            idx_q              <= '0;
            xo_q               <= '0;
            v_sync_q           <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            cls_q    <= cls_d;
            slot_q   <= slot_d;
            x_q      <= x_d;
            trig_q   <= trig_d;
            idx_q    <= idx_d;
            xo_q     <= xo_d;
            v_sync_q <= v_sync_i;
        end
    end

    assign trigger_o     = trig_q;
    assign trigger_idx_o = idx_q;
    assign trigger_x_o   = xo_q;

endmodule

// File: tb/tb_enemy_spawn_sched.sv
// ---------------------------------------------------------------------------
// tb_enemy_spawn_sched
//   Frame-level stimulus with a behavioural scheduler model. Each frame the
//   model decides the spawn (if any) and queues it with the clock cycle it
//   must appear on; an independent monitor pops and checks every pulse.
// ---------------------------------------------------------------------------
module tb_enemy_spawn_sched;

    localparam int NS = 8;

    logic        clk_vga = 1'b0;
    logic        rst;
    logic        en_i;
    logic        v_sync_i;
    logic [9:0]  rand_i;
    logic [23:0] disappear_i;
    logic [2:0]  trigger_o;
    logic [2:0]  trigger_idx_o;
    logic [8:0]  trigger_x_o;
    logic [4:0]  active_cnt_o;
    logic [1:0]  level_o;

    enemy_spawn_sched #(
        .PERIOD0     (2),
        .PERIOD1     (3),
        .PERIOD2     (5),
        .MAX_ACTIVE  (12)
`ifdef ENEMY_SPAWN_RAMP_EN
       ,.RAMP_FRAMES (4)
`endif
    ) dut (
        .clk_vga       (clk_vga),
        .rst           (rst),
        .en_i          (en_i),
        .v_sync_i      (v_sync_i),
        .rand_i        (rand_i),
        .disappear_i   (disappear_i),
        .trigger_o     (trigger_o),
        .trigger_idx_o (trigger_idx_o),
        .trigger_x_o   (trigger_x_o),
        .active_cnt_o  (active_cnt_o),
        .level_o       (level_o)
    );

    always #5 clk_vga = ~clk_vga;

    typedef struct {
        int     cls;
        int     idx;
        int     x;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   got_e;
    longint cyc = 0;
    int     total = 0;
    int     bad = 0;

    // model state
    int m_cnt[3];
    int m_rr;
    int m_level;
    int m_fc;
    int m_period[3] = '{2, 3, 5};
    int last_idx;
    int last_x;

    always @(posedge clk_vga) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) m_cnt[c] = m_period[c];
        m_rr     = 0;
        m_level  = 0;
        m_fc     = 0;
        last_idx = 0;
        last_x   = 0;
    endtask

    // Monitor: every pulse must match the oldest queued expectation
    always @(negedge clk_vga) begin
        if (trigger_o != 3'b000) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_trigger: got trigger_o=%b expected no pulse (cycle %0d)",
                         trigger_o, cyc);
            end else begin
                got_e = exp_q.pop_front();
                chk("trigger_onehot", longint'(trigger_o), longint'(3'b001 << got_e.cls));
                chk("trigger_idx", longint'(trigger_idx_o), longint'(got_e.idx));
                chk("trigger_x", longint'(trigger_x_o), longint'(got_e.x));
                chk("trigger_latency", cyc, got_e.cyc);
            end
        end
    end

    // mode: 0 normal, 1 en drop in arbitration, 2 en drop in fire, 3 reset in pulse cycle
    task automatic do_frame(input bit en, input int mode, input logic [23:0] dis, input logic [9:0] rnd);
        longint t0;
        int     c;
        int     r;
        bit     granted;
        @(negedge clk_vga);
        en_i        = en;
        v_sync_i    = 1'b1;
        disappear_i = dis;
        rand_i      = rnd;
        t0          = cyc;
        #1;
        chk("active_cnt", longint'(active_cnt_o), longint'($countones(~dis)));
        chk("level", longint'(level_o), longint'(m_level));
        chk("idx_hold", longint'(trigger_idx_o), longint'(last_idx));
        chk("x_hold", longint'(trigger_x_o), longint'(last_x));
        if (en) begin
`ifdef ENEMY_SPAWN_RAMP_EN
            m_fc++;
            if (m_fc == 4) begin
                m_fc = 0;
                if (m_level < 3) m_level++;
            end
`endif
            for (int k = 0; k < 3; k++) if (m_cnt[k] > 0) m_cnt[k]--;
            if (mode == 0) begin
                granted = 1'b0;
                for (int k = 0; k < 3 && !granted; k++) begin
                    c = (m_rr + k) % 3;
                    if (m_cnt[c] == 0 && $countones(~dis) < 12 && dis[c*NS +: NS] != 8'h00) begin
                        granted = 1'b1;
                        for (int i = NS - 1; i >= 0; i--) if (dis[c*NS + i]) last_idx = i;
                        last_x = int'(rnd) % 400;
                        exp_q.push_back('{c, last_idx, last_x, t0 + 3});
                        r = m_period[c] >> m_level;
                        m_cnt[c] = (r < 1) ? 1 : r;
                        m_rr = (c + 1) % 3;
                    end
                end
            end
        end
        @(negedge clk_vga);
        v_sync_i = 1'b0;
        if (mode == 1) en_i = 1'b0;
        @(negedge clk_vga);
        if (mode == 2) en_i = 1'b0;
        if (mode == 3) begin
            @(posedge clk_vga);
            #1 rst = 1'b1;
            #1;
            chk("rst_trigger", longint'(trigger_o), 0);
            chk("rst_idx", longint'(trigger_idx_o), 0);
            chk("rst_level", longint'(level_o), 0);
            @(negedge clk_vga);
            rst = 1'b0;
            model_reset();
        end
        repeat (6) @(negedge clk_vga);
        chk("pulse_arrived", longint'(exp_q.size()), 0);
    endtask

    initial begin
        int     sel;
        int     mode;
        bit     en;
        logic [23:0] dis;
        rst         = 1'b1;
        en_i        = 1'b0;
        v_sync_i    = 1'b0;
        rand_i      = 10'd0;
        disappear_i = '1;
        model_reset();
        repeat (3) @(posedge clk_vga);
        #1;
        chk("reset_trigger", longint'(trigger_o), 0);
        chk("reset_idx", longint'(trigger_idx_o), 0);
        chk("reset_x", longint'(trigger_x_o), 0);
        chk("reset_level", longint'(level_o), 0);
        @(negedge clk_vga);
        rst = 1'b0;

        // directed frames
        do_frame(1'b1, 0, 24'hFFFFFF, 10'd650);
        do_frame(1'b1, 0, 24'hFFFFFF, 10'd650);
        do_frame(1'b1, 0, 24'hFFFFFF, 10'd399);
        do_frame(1'b1, 0, 24'hFFFFF8, 10'd400);
        do_frame(1'b1, 0, 24'hFFF000, 10'd10);
        do_frame(1'b1, 0, 24'hFF00FF, 10'd799);
        do_frame(1'b1, 1, 24'hFFFFFF, 10'd5);
        do_frame(1'b1, 0, 24'hFFFFFF, 10'd6);
        do_frame(1'b1, 2, 24'hFFFFFF, 10'd7);
        do_frame(1'b1, 0, 24'hFFFFFF, 10'd8);
        do_frame(1'b0, 0, 24'hFFFFFF, 10'd9);
        do_frame(1'b1, 3, 24'hFFFFFF, 10'd11);
        do_frame(1'b1, 0, 24'hFFFFFF, 10'd12);

        // randomized frames
        for (int f = 0; f < 400; f++) begin
            sel = $urandom_range(3, 0);
            case (sel)
                0: dis = 24'($urandom);
                1: dis = 24'($urandom | $urandom);
                2: dis = '1;
                default: begin
                    dis = 24'($urandom | $urandom | $urandom);
                    dis[$urandom_range(2, 0)*NS +: NS] = 8'h00;
                end
            endcase
            sel  = $urandom_range(99, 0);
            en   = (sel >= 4);
            mode = (sel < 4) ? 0 : (sel < 8) ? 1 : (sel < 12) ? 2 : (sel < 14) ? 3 : 0;
            do_frame(en, mode, dis, 10'($urandom_range(799, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
